hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the 32-bit MIPS datapath.
- Sits in the EX stage.
- Its hi/lo outputs feed the writeback-select 4:1 mux (mfhi/mflo source inputs).
- Its busy output feeds the hazard logic, which stalls mfhi/mflo and further mult/div while an operation is in flight.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. Supported values are even and >= 4.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- start  input  1  op valid; sampled on the rising edge
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved
- rs_val  input  WIDTH  multiplicand / dividend / MTHI-MTLO data
- rt_val  input  WIDTH  multiplier / divisor
- busy  output  1  high while a mult/div is in flight
- done  output  1  one-cycle pulse in the first cycle new HI/LO values are visible
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset: state=IDLE; hi=0, lo=0, busy=0, done=0. All internal counters and accumulators are cleared.
- Reset mid-operation: aborts the operation, produces no done pulse, and HI/LO go to 0.
- States: IDLE, PREP, CALC, FIX. busy = (state != IDLE). done is a registered signal.
- IDLE, start=1, op=MTHI: hi<=rs_val on that edge; lo unchanged; no busy, no done.
- IDLE, start=1, op=MTLO: same as MTHI, but for lo.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU: latch operands and op; go to PREP.
- start with a reserved op, or start while busy=1: ignored. No state change, HI/LO untouched. Hazard logic must prevent this.
- PREP (1 cycle):
  - Signed ops: take magnitudes of rs_val/rt_val; record the result sign and remainder sign.
  - Unsigned ops: use operands as-is.
  - Clear iteration counter; go to CALC.
- CALC (exactly WIDTH cycles, counter 0..WIDTH-1):
  - Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH-bit accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - After the last iteration, go to FIX.
- FIX (1 cycle): apply signs, write hi/lo, set done=1 for the next cycle, go to IDLE.
  - Multiply: {hi,lo} = product. Negated (2's complement, 2*WIDTH bits) if sign(rs) != sign(rt) for MULT.
  - Divide: lo = quotient, hi = remainder.
  - DIV: quotient negated if operand signs differ; remainder takes the dividend's sign.
- Latency: start sampled at edge 0.
  - busy is high from after edge 0 until edge WIDTH+2 (34 for WIDTH=32).
  - New hi/lo and done=1 appear after edge WIDTH+2.
  - busy=0 in that same cycle, so a new start may be accepted at edge WIDTH+3.
- HI/LO hold their previous values for the whole operation; no partial results are visible.
- Divide by zero (DIV and DIVU): full latency, done pulses; lo = all ones, hi = rs_val.
- DIV overflow (0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0.
- MULT of two minimum-negative values: {hi,lo} = 0x40000000_00000000.

Test Plan:
- Reset, then MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF
  -> busy high 34 cycles; done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT rs=0xFFFFFFFD (-3) rt=0x00000007
  -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV rs=0xFFFFFFF9 (-7) rt=0x00000002
  -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU rs=100 rt=7 -> lo=14, hi=2.
- DIVU rs=0x1234 rt=0 -> lo=0xFFFFFFFF, hi=0x1234.
- MTHI 0xAAAA5555 then MTLO 0x5555AAAA on back-to-back edges
  -> hi/lo update the cycle after each edge; busy and done stay 0.
- Start MULTU 5*6.
  - At cycle 10 assert start with op=MTLO 0x1: ignored.
  - At cycle 20 assert Reset for 1 cycle: hi=lo=0, busy=0, no done.
  - Then MULTU 5*6 completes: lo=30, hi=0.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative mult/div unit with architectural HI/LO registers
// Shift-add multiply and restoring divide, one bit per cycle; signs applied in FIX.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic                 is_div, is_uns, neg_res, neg_rem, div_zero;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   acc;

  logic                 neg_a, neg_b, last_iter;
  logic [WIDTH-1:0]     mag_a, mag_b, mul_add, quot_fix, rem_fix;
  logic [WIDTH:0]       mul_sum, rem_sh, trial;
  logic [2*WIDTH-1:0]   prod_fix;

  assign busy      = (state != IDLE);
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // In PREP a_q/b_q still hold the raw operands; afterwards they hold magnitudes.
  assign neg_a = ~is_uns & a_q[WIDTH-1];
  assign neg_b = ~is_uns & b_q[WIDTH-1];
  assign mag_a = neg_a ? -a_q : a_q;
  assign mag_b = neg_b ? -b_q : b_q;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_add = acc[0] ? a_q : '0;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}.
  assign rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, b_q};

  assign prod_fix = neg_res ? -acc : acc;
  assign quot_fix = div_zero ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !op[2]) state_nxt = PREP;
      PREP: state_nxt = CALC;
      CALC: if (last_iter) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      is_div   <= 1'b0;
      is_uns   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'b100: hi <= rs_val;
              3'b101: lo <= rs_val;
              3'b000, 3'b001, 3'b010, 3'b011: begin
                a_q    <= rs_val;
                b_q    <= rt_val;
                is_div <= op[1];
                is_uns <= op[0];
              end
              default: ;
            endcase
          end
        end
        PREP: begin
          a_q      <= mag_a;
          b_q      <= mag_b;
          neg_res  <= neg_a ^ neg_b;
          neg_rem  <= neg_a;
          div_zero <= is_div && (b_q == '0);
          cnt      <= '0;
          acc      <= is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (!is_div)
            acc <= {mul_sum, acc[WIDTH-1:1]};
          else if (!trial[WIDTH])
            acc <= {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else
            acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
        FIX: begin
          if (is_div) begin
            lo <= quot_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - directed vector bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    logic [31:0] old_hi, old_lo;
    int          nbusy;
    logic        held, early_done;
    @(negedge Clk);
    old_hi = hi;
    old_lo = lo;
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(negedge Clk);
    start      = 1'b0;
    nbusy      = 0;
    held       = 1'b1;
    early_done = 1'b0;
    while (busy && nbusy < 100) begin
      nbusy++;
      if (hi !== old_hi || lo !== old_lo) held = 1'b0;
      if (done) early_done = 1'b1;
      @(negedge Clk);
    end
    chk({name, " busy_cycles"}, 64'(nbusy), 64'd34);
    chk({name, " hold"}, {63'd0, held}, 64'd1);
    chk({name, " no_early_done"}, {63'd0, early_done}, 64'd0);
    chk({name, " done"}, {63'd0, done}, 64'd1);
    chk({name, " hi"}, {32'd0, hi}, {32'd0, eh});
    chk({name, " lo"}, {32'd0, lo}, {32'd0, el});
    @(negedge Clk);
    chk({name, " done_drop"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    vecs[0]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4]  = '{3'b011, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[5]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7]  = '{3'b010, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[8]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    vecs[10] = '{3'b000, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};

    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo);

    // MTHI then MTLO on back-to-back edges
    @(negedge Clk);
    start = 1'b1; op = 3'b100; rs_val = 32'hAAAA5555;
    @(negedge Clk);
    chk("mthi hi", {32'd0, hi}, {32'd0, 32'hAAAA5555});
    chk("mthi busy_done", {62'd0, busy, done}, 64'd0);
    op = 3'b101; rs_val = 32'h5555AAAA;
    @(negedge Clk);
    start = 1'b0;
    chk("mtlo lo", {32'd0, lo}, {32'd0, 32'h5555AAAA});
    chk("mtlo hi_kept", {32'd0, hi}, {32'd0, 32'hAAAA5555});
    chk("mtlo busy_done", {62'd0, busy, done}, 64'd0);

    // Reserved op while idle is ignored
    start = 1'b1; op = 3'b110; rs_val = 32'h12345678;
    @(negedge Clk);
    start = 1'b0;
    chk("reserved hilo", {hi, lo}, {32'hAAAA5555, 32'h5555AAAA});
    chk("reserved busy", {63'd0, busy}, 64'd0);

    // Start while busy is ignored; reset mid-operation aborts
    start = 1'b1; op = 3'b001; rs_val = 32'd5; rt_val = 32'd6;
    @(negedge Clk);
    start = 1'b0;
    repeat (9) @(negedge Clk);
    start = 1'b1; op = 3'b101; rs_val = 32'h1;
    @(negedge Clk);
    start = 1'b0;
    chk("busy_start lo", {32'd0, lo}, {32'd0, 32'h5555AAAA});
    chk("busy_start busy", {63'd0, busy}, 64'd1);
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort hilo", {hi, lo}, 64'd0);
    chk("abort busy", {63'd0, busy}, 64'd0);
    begin
      logic saw_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (done || busy) saw_done = 1'b1;
        @(negedge Clk);
      end
      chk("abort quiet", {63'd0, saw_done}, 64'd0);
    end

    run_op("multu5x6", 3'b001, 32'd5, 32'd6, 32'd0, 32'd30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
